// File: rtl/display_pkg.sv
// Shared constants for the DVI output path: mode table, timing sets and
// sequencer state encoding.
package display_pkg;

   localparam int MODE_COUNT = 3;
   localparam int MODE_W     = 2;
   localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(MODE_COUNT - 1);

   localparam logic [MODE_W-1:0] MODE_720P60  = 2'd0;
   localparam logic [MODE_W-1:0] MODE_720P50  = 2'd1;
   localparam logic [MODE_W-1:0] MODE_1080P30 = 2'd2;

   localparam logic [2:0] S_RESET     = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_WAIT_HPD  = 3'd2;
   localparam logic [2:0] S_STARTUP   = 3'd3;
   localparam logic [2:0] S_SYNC      = 3'd4;
   localparam logic [2:0] S_ACTIVE    = 3'd5;
   localparam logic [2:0] S_DRAIN     = 3'd6;
   localparam logic [2:0] S_SWITCH    = 3'd7;

   typedef enum logic [2:0] {
      ST_RESET     = S_RESET,
      ST_WAIT_LOCK = S_WAIT_LOCK,
      ST_WAIT_HPD  = S_WAIT_HPD,
      ST_STARTUP   = S_STARTUP,
      ST_SYNC      = S_SYNC,
      ST_ACTIVE    = S_ACTIVE,
      ST_DRAIN     = S_DRAIN,
      ST_SWITCH    = S_SWITCH
   } state_e;

   typedef struct packed {
      logic [11:0] h_res;
      logic [11:0] v_res;
      logic [11:0] h_fp;
      logic [11:0] h_sync;
      logic [11:0] h_bp;
      logic [11:0] v_fp;
      logic [11:0] v_sync;
      logic [11:0] v_bp;
      logic        h_pol;
      logic        v_pol;
   } timing_t;

   // All three modes share the 74.25 MHz pixel clock.
   localparam timing_t T_720P60 = '{
      h_res: 12'd1280, v_res: 12'd720,
      h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
      v_fp: 12'd5, v_sync: 12'd5, v_bp: 12'd20,
      h_pol: 1'b1, v_pol: 1'b1};

   localparam timing_t T_720P50 = '{
      h_res: 12'd1280, v_res: 12'd720,
      h_fp: 12'd440, h_sync: 12'd40, h_bp: 12'd220,
      v_fp: 12'd5, v_sync: 12'd5, v_bp: 12'd20,
      h_pol: 1'b1, v_pol: 1'b1};

   localparam timing_t T_1080P30 = '{
      h_res: 12'd1920, v_res: 12'd1080,
      h_fp: 12'd88, h_sync: 12'd44, h_bp: 12'd148,
      v_fp: 12'd4, v_sync: 12'd5, v_bp: 12'd36,
      h_pol: 1'b1, v_pol: 1'b1};

   function automatic timing_t mode_timing(input logic [MODE_W-1:0] m);
      timing_t t;
      t = T_720P60;
      if (m == MODE_720P50) t = T_720P50;
      if (m == MODE_1080P30) t = T_1080P30;
      return t;
   endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer.
// The output flips only after the input differs for CYCLES cycles.
module sync_debounce #(
   parameter int CYCLES = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic level_o
);

   localparam int CNT_W = $clog2(CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             db_q;
   logic             db_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = ~db_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= async_i;
         s2_q  <= s1_q;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign level_o = db_q;

endmodule

// File: rtl/display_link_sequencer.sv
// Power-up, hot-plug and mode-change sequencer for the DVI output path.
// Mode changes are applied at a frame boundary with the output blanked.
module display_link_sequencer
   import display_pkg::*;
#(
   parameter int                SETTLE_CYCLES = 16,
   parameter int                HPD_DEBOUNCE  = 1024,
   parameter logic [MODE_W-1:0] DEFAULT_MODE  = 2'd0
) (
   input  logic              i_pix_clk,
   input  logic              i_rst,
   input  logic              i_clk_lock,
   input  logic              i_hpd,
   input  logic              i_frame,
   input  logic [MODE_W-1:0] i_mode_req,
   input  logic              i_mode_valid,
   output logic              o_mode_ready,
   output logic              o_mode_err,
   output logic [MODE_W-1:0] o_mode,
   output logic              o_ser_rst,
   output logic              o_timing_rst,
   output logic              o_blank,
   output logic              o_tx_en,
   output logic [2:0]        o_state
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [MODE_W-1:0] pend_q, pend_d;
   logic              lock_s1_q, lock_q;
   logic              hpd_db;
   logic              accept;
   logic              req_ok;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              ser_q, ser_d;
   logic              tim_q, tim_d;
   logic              blank_q, blank_d;
   logic              tx_q, tx_d;

   sync_debounce #(
      .CYCLES (HPD_DEBOUNCE)
   ) u_hpd (
      .clk_i   (i_pix_clk),
      .rst_i   (i_rst),
      .async_i (i_hpd),
      .level_o (hpd_db)
   );

   assign accept = i_mode_valid & ready_q;
   assign req_ok = (i_mode_req <= MODE_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      mode_d  = mode_q;
      pend_d  = pend_q;
      // Aborts override the normal flow; lock loss outranks HPD loss.
      if (!(state_q inside {ST_RESET, ST_WAIT_LOCK}) && !lock_q) begin
         state_d = ST_WAIT_LOCK;
      end else if (!(state_q inside {ST_RESET, ST_WAIT_LOCK, ST_WAIT_HPD})
                   && !hpd_db) begin
         state_d = ST_WAIT_HPD;
      end else begin
         unique case (state_q)
            ST_RESET:     state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (lock_q) state_d = ST_WAIT_HPD;
            ST_WAIT_HPD:  if (hpd_db) state_d = ST_STARTUP;
            ST_STARTUP,
            ST_SWITCH: begin
               if (cnt_q == CNT_LAST) state_d = ST_SYNC;
               else cnt_d = cnt_q + CNT_W'(1);
            end
            ST_SYNC:      if (i_frame) state_d = ST_ACTIVE;
            ST_ACTIVE: begin
               if (accept && req_ok && (i_mode_req != mode_q)) begin
                  pend_d  = i_mode_req;
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (i_frame) begin
                  mode_d  = pend_q;
                  state_d = ST_SWITCH;
               end
            end
         endcase
      end
   end

   always_comb begin
      ready_d = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) && !accept;
      err_d   = accept && !req_ok;
      ser_d   = state_q inside {ST_RESET, ST_WAIT_LOCK};
      tim_d   = state_q inside {ST_RESET, ST_WAIT_LOCK, ST_WAIT_HPD,
                                ST_STARTUP, ST_SWITCH};
      blank_d = (state_q != ST_ACTIVE);
      tx_d    = state_q inside {ST_STARTUP, ST_SYNC, ST_ACTIVE,
                                ST_DRAIN, ST_SWITCH};
   end

   always_ff @(posedge i_pix_clk) begin
      if (i_rst) begin
         state_q   <= ST_RESET;
         cnt_q     <= '0;
         mode_q    <= DEFAULT_MODE;
         pend_q    <= DEFAULT_MODE;
         lock_s1_q <= 1'b0;
         lock_q    <= 1'b0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
         ser_q     <= 1'b1;
         tim_q     <= 1'b1;
         blank_q   <= 1'b1;
         tx_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         pend_q    <= pend_d;
         lock_s1_q <= i_clk_lock;
         lock_q    <= lock_s1_q;
         ready_q   <= ready_d;
         err_q     <= err_d;
         ser_q     <= ser_d;
         tim_q     <= tim_d;
         blank_q   <= blank_d;
         tx_q      <= tx_d;
      end
   end

   assign o_state      = state_q;
   assign o_mode       = mode_q;
   assign o_mode_ready = ready_q;
   assign o_mode_err   = err_q;
   assign o_ser_rst    = ser_q;
   assign o_timing_rst = tim_q;
   assign o_blank      = blank_q;
   assign o_tx_en      = tx_q;

endmodule

// File: tb/tb_display_link_sequencer.sv
// Self-checking bench for display_link_sequencer with randomized requests,
// glitches and abort points against a behavioural model of the mode rules.
module tb_display_link_sequencer;

   localparam int SETTLE = 16;
   localparam int DEB    = 1024;
   localparam int MODES  = 3;

   localparam logic [2:0] T_RESET  = 3'd0;
   localparam logic [2:0] T_WLOCK  = 3'd1;
   localparam logic [2:0] T_WHPD   = 3'd2;
   localparam logic [2:0] T_START  = 3'd3;
   localparam logic [2:0] T_SYNC   = 3'd4;
   localparam logic [2:0] T_ACTIVE = 3'd5;
   localparam logic [2:0] T_DRAIN  = 3'd6;
   localparam logic [2:0] T_SWITCH = 3'd7;

   logic       clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_clk_lock = 1'b0;
   logic       i_hpd = 1'b0;
   logic       i_frame = 1'b0;
   logic [1:0] i_mode_req = 2'd0;
   logic       i_mode_valid = 1'b0;
   logic       o_mode_ready, o_mode_err;
   logic [1:0] o_mode;
   logic       o_ser_rst, o_timing_rst, o_blank, o_tx_en;
   logic [2:0] o_state;

   int         checks = 0;
   int         fails  = 0;
   logic [1:0] exp_mode = 2'd0;

   always #5 clk = ~clk;

   display_link_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .HPD_DEBOUNCE  (DEB),
      .DEFAULT_MODE  (2'd0)
   ) dut (
      .i_pix_clk    (clk),
      .i_rst        (i_rst),
      .i_clk_lock   (i_clk_lock),
      .i_hpd        (i_hpd),
      .i_frame      (i_frame),
      .i_mode_req   (i_mode_req),
      .i_mode_valid (i_mode_valid),
      .o_mode_ready (o_mode_ready),
      .o_mode_err   (o_mode_err),
      .o_mode       (o_mode),
      .o_ser_rst    (o_ser_rst),
      .o_timing_rst (o_timing_rst),
      .o_blank      (o_blank),
      .o_tx_en      (o_tx_en),
      .o_state      (o_state)
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame();
      i_frame = 1'b1;
      tick();
      i_frame = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget,
                             output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (o_state === st) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic bring_up(output bit ok);
      int n;
      wait_state(T_SYNC, DEB + 300, n);
      tick(2);
      pulse_frame();
      ok = (n > 0) && (o_state === T_ACTIVE);
      tick();
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      i_clk_lock = 1'b1;
      i_hpd = 1'b1;
      tick(3);
      checks++;
      if ({o_state, o_ser_rst, o_timing_rst, o_blank, o_tx_en}
          !== {T_RESET, 1'b1, 1'b1, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL reset_ctrl: got st=%0d ser=%b tim=%b blk=%b tx=%b want st=0 1 1 1 0",
                  o_state, o_ser_rst, o_timing_rst, o_blank, o_tx_en);
      end
      checks++;
      if ({o_mode, o_mode_ready, o_mode_err} !== {2'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_mode: got mode=%0d rdy=%b err=%b want 0 0 0",
                  o_mode, o_mode_ready, o_mode_err);
      end
   endtask

   task automatic test_powerup();
      int n, total, dwell, gap;
      i_rst = 1'b0;
      tick();
      checks++;
      if (o_state !== T_WLOCK) begin
         fails++;
         $display("FAIL pu_wait_lock: got %0d want %0d", o_state, T_WLOCK);
      end
      wait_state(T_WHPD, 5, n);
      checks++;
      if (n < 1 || n > 3) begin
         fails++;
         $display("FAIL pu_wait_hpd: got %0d cycles want 1..3", n);
      end
      total = 1 + n;
      wait_state(T_START, DEB + 20, n);
      total += n;
      checks++;
      if (n < 0 || total < DEB || total > DEB + 4) begin
         fails++;
         $display("FAIL pu_startup_time: got %0d cycles want %0d..%0d",
                  total, DEB, DEB + 4);
      end
      dwell = 0;
      do begin
         dwell++;
         i_frame = (dwell == 4);
         tick();
         i_frame = 1'b0;
         if (dwell == 2) begin
            checks++;
            if ({o_ser_rst, o_timing_rst, o_blank, o_tx_en} !== 4'b0111) begin
               fails++;
               $display("FAIL pu_startup_outs: got %b%b%b%b want 0111",
                        o_ser_rst, o_timing_rst, o_blank, o_tx_en);
            end
         end
      end while (o_state === T_START && dwell < 64);
      checks++;
      if (dwell != SETTLE || o_state !== T_SYNC) begin
         fails++;
         $display("FAIL pu_settle: got %0d cycles st=%0d want %0d st=%0d",
                  dwell, o_state, SETTLE, T_SYNC);
      end
      gap = 1 + $urandom_range(0, 30);
      tick(gap);
      checks++;
      if ({o_state, o_timing_rst, o_blank} !== {T_SYNC, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL pu_sync: got st=%0d tim=%b blk=%b want %0d 0 1",
                  o_state, o_timing_rst, o_blank, T_SYNC);
      end
      pulse_frame();
      tick();
      checks++;
      if ({o_state, o_blank, o_mode_ready, o_tx_en}
          !== {T_ACTIVE, 1'b0, 1'b1, 1'b1}) begin
         fails++;
         $display("FAIL pu_active: got st=%0d blk=%b rdy=%b tx=%b want %0d 0 1 1",
                  o_state, o_blank, o_mode_ready, o_tx_en, T_ACTIVE);
      end
   endtask

   task automatic test_requests();
      logic [1:0] req;
      int dwell, gap;
      for (int k = 0; k < 12; k++) begin
         req = (k == 0) ? 2'd2 : 2'($urandom_range(0, 3));
         checks++;
         if (o_mode_ready !== 1'b1 || o_state !== T_ACTIVE) begin
            fails++;
            $display("FAIL req%0d_ready: got rdy=%b st=%0d want 1 %0d",
                     k, o_mode_ready, o_state, T_ACTIVE);
         end
         i_mode_valid = 1'b1;
         i_mode_req = req;
         i_frame = 1'($urandom_range(0, 1));
         tick();
         i_frame = 1'b0;
         if (int'(req) >= MODES) begin
            i_mode_valid = 1'b0;
            checks++;
            if ({o_state, o_mode_err, o_mode_ready} !== {T_ACTIVE, 1'b1, 1'b0}) begin
               fails++;
               $display("FAIL req%0d_err: got st=%0d err=%b rdy=%b want %0d 1 0",
                        k, o_state, o_mode_err, o_mode_ready, T_ACTIVE);
            end
            tick();
            checks++;
            if ({o_mode_err, o_mode, o_mode_ready} !== {1'b0, exp_mode, 1'b1}) begin
               fails++;
               $display("FAIL req%0d_err_after: got err=%b mode=%0d rdy=%b want 0 %0d 1",
                        k, o_mode_err, o_mode, o_mode_ready, exp_mode);
            end
         end else if (req == exp_mode) begin
            i_mode_valid = 1'b0;
            checks++;
            if ({o_state, o_mode_err, o_mode_ready} !== {T_ACTIVE, 1'b0, 1'b0}) begin
               fails++;
               $display("FAIL req%0d_noop: got st=%0d err=%b rdy=%b want %0d 0 0",
                        k, o_state, o_mode_err, o_mode_ready, T_ACTIVE);
            end
            tick();
            checks++;
            if ({o_mode, o_mode_ready, o_blank} !== {exp_mode, 1'b1, 1'b0}) begin
               fails++;
               $display("FAIL req%0d_noop_after: got mode=%0d rdy=%b blk=%b want %0d 1 0",
                        k, o_mode, o_mode_ready, o_blank, exp_mode);
            end
         end else begin
            checks++;
            if ({o_state, o_mode_ready, o_mode_err} !== {T_DRAIN, 1'b0, 1'b0}) begin
               fails++;
               $display("FAIL req%0d_accept: got st=%0d rdy=%b err=%b want %0d 0 0",
                        k, o_state, o_mode_ready, o_mode_err, T_DRAIN);
            end
            tick();
            checks++;
            if ({o_blank, o_mode_ready} !== 2'b10) begin
               fails++;
               $display("FAIL req%0d_drain_blank: got blk=%b rdy=%b want 1 0",
                        k, o_blank, o_mode_ready);
            end
            gap = $urandom_range(0, 20);
            tick(gap);
            checks++;
            if ({o_state, o_mode, o_mode_ready} !== {T_DRAIN, exp_mode, 1'b0}) begin
               fails++;
               $display("FAIL req%0d_drain_hold: got st=%0d mode=%0d rdy=%b want %0d %0d 0",
                        k, o_state, o_mode, o_mode_ready, T_DRAIN, exp_mode);
            end
            i_mode_valid = 1'b0;
            pulse_frame();
            checks++;
            if ({o_state, o_mode} !== {T_SWITCH, req}) begin
               fails++;
               $display("FAIL req%0d_switch: got st=%0d mode=%0d want %0d %0d",
                        k, o_state, o_mode, T_SWITCH, req);
            end
            dwell = 0;
            do begin
               dwell++;
               i_frame = (dwell == 3);
               tick();
               i_frame = 1'b0;
               if (dwell == 2) begin
                  checks++;
                  if ({o_timing_rst, o_blank, o_ser_rst} !== 3'b110) begin
                     fails++;
                     $display("FAIL req%0d_switch_outs: got tim=%b blk=%b ser=%b want 1 1 0",
                              k, o_timing_rst, o_blank, o_ser_rst);
                  end
               end
            end while (o_state === T_SWITCH && dwell < 64);
            checks++;
            if (dwell != SETTLE || o_state !== T_SYNC) begin
               fails++;
               $display("FAIL req%0d_switch_len: got %0d st=%0d want %0d st=%0d",
                        k, dwell, o_state, SETTLE, T_SYNC);
            end
            tick(2);
            pulse_frame();
            tick();
            exp_mode = req;
            checks++;
            if ({o_state, o_mode, o_blank, o_mode_ready}
                !== {T_ACTIVE, exp_mode, 1'b0, 1'b1}) begin
               fails++;
               $display("FAIL req%0d_resume: got st=%0d mode=%0d blk=%b rdy=%b want %0d %0d 0 1",
                        k, o_state, o_mode, o_blank, o_mode_ready, T_ACTIVE, exp_mode);
            end
         end
      end
   endtask

   task automatic test_hpd();
      int len, n;
      bit stay, ok;
      len = $urandom_range(80, 300);
      stay = 1'b1;
      i_hpd = 1'b0;
      tick(len);
      i_hpd = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (o_state !== T_ACTIVE || o_blank !== 1'b0) stay = 1'b0;
         tick();
      end
      checks++;
      if (!stay || o_state !== T_ACTIVE) begin
         fails++;
         $display("FAIL hpd_glitch: glitch of %0d cycles left st=%0d want %0d",
                  len, o_state, T_ACTIVE);
      end
      i_hpd = 1'b0;
      wait_state(T_WHPD, DEB + 20, n);
      checks++;
      if (n < DEB || n > DEB + 4) begin
         fails++;
         $display("FAIL hpd_loss_time: got %0d cycles want %0d..%0d",
                  n, DEB, DEB + 4);
      end
      tick();
      checks++;
      if ({o_blank, o_tx_en, o_ser_rst, o_timing_rst} !== 4'b1001) begin
         fails++;
         $display("FAIL hpd_loss_outs: got blk=%b tx=%b ser=%b tim=%b want 1 0 0 1",
                  o_blank, o_tx_en, o_ser_rst, o_timing_rst);
      end
      i_hpd = 1'b1;
      bring_up(ok);
      checks++;
      if (!ok || o_mode !== exp_mode) begin
         fails++;
         $display("FAIL hpd_recover: got st=%0d mode=%0d want %0d %0d",
                  o_state, o_mode, T_ACTIVE, exp_mode);
      end
   endtask

   task automatic test_lock_drop();
      logic [1:0] req;
      int n;
      bit ok;
      req = 2'((int'(exp_mode) + 1 + $urandom_range(0, 1)) % MODES);
      i_mode_valid = 1'b1;
      i_mode_req = req;
      tick();
      i_mode_valid = 1'b0;
      checks++;
      if (o_state !== T_DRAIN) begin
         fails++;
         $display("FAIL lock_pre_drain: got %0d want %0d", o_state, T_DRAIN);
      end
      tick($urandom_range(0, 5));
      i_clk_lock = 1'b0;
      wait_state(T_WLOCK, 3, n);
      checks++;
      if (n < 0) begin
         fails++;
         $display("FAIL lock_loss_time: got st=%0d after 3 cycles want %0d",
                  o_state, T_WLOCK);
      end
      tick();
      checks++;
      if ({o_ser_rst, o_timing_rst, o_blank, o_tx_en, o_mode, o_mode_ready}
          !== {4'b1110, exp_mode, 1'b0}) begin
         fails++;
         $display("FAIL lock_loss_outs: got ser=%b tim=%b blk=%b tx=%b mode=%0d rdy=%b want 1 1 1 0 %0d 0",
                  o_ser_rst, o_timing_rst, o_blank, o_tx_en, o_mode,
                  o_mode_ready, exp_mode);
      end
      i_clk_lock = 1'b1;
      bring_up(ok);
      pulse_frame();
      tick();
      checks++;
      if (!ok || o_state !== T_ACTIVE || o_mode !== exp_mode) begin
         fails++;
         $display("FAIL lock_recover: got ok=%b st=%0d mode=%0d want 1 %0d %0d",
                  ok, o_state, o_mode, T_ACTIVE, exp_mode);
      end
   endtask

   task automatic test_rst_switch();
      logic [1:0] req;
      if (exp_mode == 2'd1) req = 2'd2;
      else if (exp_mode == 2'd2) req = 2'd1;
      else req = 2'($urandom_range(1, 2));
      i_mode_valid = 1'b1;
      i_mode_req = req;
      tick();
      i_mode_valid = 1'b0;
      tick(2);
      pulse_frame();
      checks++;
      if ({o_state, o_mode} !== {T_SWITCH, req}) begin
         fails++;
         $display("FAIL rst_pre_switch: got st=%0d mode=%0d want %0d %0d",
                  o_state, o_mode, T_SWITCH, req);
      end
      tick($urandom_range(1, 10));
      i_rst = 1'b1;
      tick();
      checks++;
      if ({o_state, o_ser_rst, o_timing_rst, o_blank, o_tx_en,
           o_mode, o_mode_ready, o_mode_err}
          !== {T_RESET, 4'b1110, 2'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL rst_mid_switch: got st=%0d ser=%b tim=%b blk=%b tx=%b mode=%0d rdy=%b err=%b want 0 1 1 1 0 0 0 0",
                  o_state, o_ser_rst, o_timing_rst, o_blank, o_tx_en,
                  o_mode, o_mode_ready, o_mode_err);
      end
      i_rst = 1'b0;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_requests();
      test_hpd();
      test_lock_drop();
      test_rst_switch();
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
